// File: rtl/clock_pkg.sv
// Shared definitions for the clock/display subsystem: mode encodings,
// scheduler state type and the DIP-switch mode decoder.
package clock_pkg;

  localparam logic [1:0] MODE_WATCH     = 2'd0;
  localparam logic [1:0] MODE_SET       = 2'd1;
  localparam logic [1:0] MODE_ALARM     = 2'd2;
  localparam logic [1:0] MODE_STOPWATCH = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_PEND       = 2'd1,
    ST_ALARM_PEND = 2'd2,
    ST_ALARM      = 2'd3
  } sched_state_e;

  // One-hot DIP request to mode; anything that is not a single known bit is watch.
  function automatic logic [1:0] dip_to_mode(input logic [3:0] dip_sw);
    logic [1:0] mode;
    case (dip_sw)
      4'b0001: mode = MODE_SET;
      4'b0010: mode = MODE_ALARM;
      4'b0100: mode = MODE_STOPWATCH;
      default: mode = MODE_WATCH;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/sw_edge_detect.sv
// Turns four debounced button levels into single-cycle rising-edge pulses.
module sw_edge_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_lvl,
  output logic [3:0] press
);

  logic [3:0] sw_lvl_q;

  // Remember last cycle's levels so a held button never repeats.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) sw_lvl_q <= '0;
    else     sw_lvl_q <= sw_lvl;
  end

  assign press = sw_lvl & ~sw_lvl_q;

endmodule

// File: rtl/mode_scheduler.sv
// Display/button ownership scheduler: commits DIP mode requests on frame
// boundaries, routes press pulses to the owning mode and pre-empts the
// display for a ringing alarm.
module mode_scheduler
  import clock_pkg::*;
#(
  parameter int ALARM_HOLD_SEC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1hz,
  input  logic        frame_done,
  input  logic [3:0]  dip_sw,
  input  logic [3:0]  sw_lvl,
  input  logic        alarm_hit,
  output logic [1:0]  mode_sel,
  output logic [15:0] sw_bus,
  output logic        buzzer,
  output logic        busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(ALARM_HOLD_SEC);

  sched_state_e state, state_d;
  logic [1:0]   req;
  logic [3:0]   press;
  logic [7:0]   hold_cnt;
  logic         pending;
  logic         forced;       // PEND entered from ALARM: must commit on the frame
  logic         enter_alarm;
  logic         leave_alarm;
  logic         commit;
  logic         reload;
  logic         dec;

  assign req = dip_to_mode(dip_sw);

  sw_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .sw_lvl(sw_lvl),
    .press (press)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_d;
  end

  // Next state plus the datapath strobes that accompany each transition.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state;
    enter_alarm = 1'b0;
    leave_alarm = 1'b0;
    commit      = 1'b0;
    reload      = 1'b0;
    dec         = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (alarm_hit && frame_done) begin
          state_d     = ST_ALARM;
          enter_alarm = 1'b1;
        end else if (pending) begin
          state_d = ST_ALARM_PEND;
        end else if (req != mode_sel) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_done) begin
          state_d = ST_RUN;
          commit  = 1'b1;
        end else if (!forced && req == mode_sel) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM_PEND: begin
        if (frame_done) begin
          state_d     = ST_ALARM;
          enter_alarm = 1'b1;
        end
      end
      ST_ALARM: begin
        if (|press) begin
          state_d     = ST_PEND;
          leave_alarm = 1'b1;
        end else if (alarm_hit) begin
          reload = 1'b1;
        end else if (en_1hz) begin
          dec = 1'b1;
          if (hold_cnt <= 8'd1) begin
            state_d     = ST_PEND;
            leave_alarm = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Committed owner, hold counter, sticky alarm request and routed presses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sel <= MODE_WATCH;
      sw_bus   <= '0;
      hold_cnt <= '0;
      pending  <= 1'b0;
      forced   <= 1'b0;
    end else begin
      sw_bus <= (state == ST_RUN) ? (16'(press) << {mode_sel, 2'b00}) : '0;

      if (enter_alarm) mode_sel <= MODE_ALARM;
      else if (commit) mode_sel <= req;

      if (enter_alarm || reload)    hold_cnt <= HOLD_LOAD;
      else if (dec && hold_cnt != 0) hold_cnt <= hold_cnt - 8'd1;

      // A hit during ALARM only reloads; it must not re-arm another alarm.
      if (enter_alarm)                        pending <= 1'b0;
      else if (alarm_hit && state != ST_ALARM) pending <= 1'b1;

      if (leave_alarm)                               forced <= 1'b1;
      else if (state == ST_PEND && state_d != ST_PEND) forced <= 1'b0;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    buzzer = (state == ST_ALARM);
    busy   = (state != ST_RUN);
  end

endmodule

// File: doc/mode_scheduler.md
# mode_scheduler

Arbitrates ownership of the shared LCD character stream and the four debounced push-buttons among the four display modes (watch, watch-set, alarm, stopwatch). It decodes the DIP-switch mode request and commits mode changes only at LCD frame boundaries, so no frame is torn. It converts button levels into single-cycle press pulses routed only to the owning mode. It also pre-empts the display for a ringing alarm. It sits between the debouncers/alarm comparator and the mode blocks, and drives the top-level data mux select.

## Interface
- ALARM_HOLD_SEC, 30, alarm display/buzzer duration in en_1hz ticks (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en_1hz  in  1  one-cycle 1 Hz enable
- frame_done  in  1  one-cycle pulse from the LCD driver after the last character (index 31) of a frame is written
- dip_sw  in  4  mode request: 0001→1, 0010→2, 0100→3, any other value→0
- sw_lvl  in  4  debounced button levels, active-high
- alarm_hit  in  1  one-cycle pulse when the alarm time matches
- mode_sel  out  2  committed display owner; drives the data_char mux
- sw_bus  out  16  per-mode press pulses; mode m uses bits [4m+3:4m]
- buzzer  out  1  high while in ALARM
- busy  out  1  high in PEND, ALARM_PEND or ALARM

## Operation
- Edge detect: register sw_lvl. Press pulse p[i] = sw_lvl[i] & ~sw_lvl_q[i].
- States:
  - RUN: p goes to slot mode_sel.
    - If an alarm is pending, go to ALARM_PEND.
    - Else, if req ≠ mode_sel, go to PEND.
  - PEND: all presses dropped.
    - On frame_done, mode_sel ← req, then back to RUN.
    - If req returns to mode_sel before frame_done, go to RUN with no commit.
  - ALARM_PEND: presses dropped.
    - On frame_done, mode_sel ← 2, hold counter ← ALARM_HOLD_SEC, go to ALARM.
  - ALARM: buzzer = 1; presses are never forwarded.
    - en_1hz decrements the counter.
    - Any press, or counter reaching 0, clears buzzer and goes to PEND. PEND then restores req even if req equals 2.
- alarm_hit sets a sticky pending flag, cleared on entry to ALARM.
  - alarm_hit while in ALARM reloads the counter to ALARM_HOLD_SEC.
- Priority in RUN: pending alarm > mode change.
- req is re-evaluated every cycle; a DIP change during ALARM has no effect until ALARM exits.
- Reset values: mode_sel=0, sw_bus=0, buzzer=0, busy=0, state RUN, pending=0, counter=0, sw_lvl_q=0.

## Timing
- Press latency: a sw_lvl rise sampled at edge n produces a pulse on sw_bus (registered) during cycle n+1, exactly one cycle wide.
- A button held through a mode commit does not generate a press in the new mode; only a fresh rise does.
- mode_sel changes in the cycle after the frame_done edge that commits it.
- Simultaneous events:
  - alarm_hit and frame_done in the same cycle in RUN: enter ALARM directly at that edge; the pending flag is bypassed.
  - frame_done and a press in the same cycle in PEND: press dropped.
  - en_1hz and a press in the same cycle in ALARM: exit via the press; the counter value is irrelevant.
  - Counter reaching 0 and alarm_hit in the same cycle: reload wins; stay in ALARM.
- rst asserted mid-ALARM: buzzer drops asynchronously and the pending alarm is lost.

## Structure
- Shared package `clock_pkg`:
  - mode encodings MODE_WATCH=0, MODE_SET=1, MODE_ALARM=2, MODE_STOPWATCH=3
  - scheduler state enum (RUN, PEND, ALARM_PEND, ALARM)
  - function dip_to_mode(dip_sw) returning the 2-bit mode
- Sub-module `sw_edge_detect`: 4-bit level register plus rising-edge pulse, asynchronous active-high reset.
- Top owns the FSM, pending flag, 8-bit hold counter and sw_bus routing.

## Test plan
- Reset, dip_sw=0001 → busy=1, mode_sel stays 0 until the first frame_done, becomes 1 the next cycle; press sw_lvl[2] → sw_bus=16'h0040 for one cycle.
- dip_sw=0100, press sw_lvl[0] before frame_done → sw_bus stays 0; dip_sw back to 0000 before frame_done → state RUN, mode_sel=0, no commit.
- Mode 3, alarm_hit, frame_done 50 cycles later → mode_sel=2 and buzzer=1 from that point; press sw_lvl[1] → buzzer=0, sw_bus stays 0, mode_sel returns to 3 after the next frame_done.
- ALARM_HOLD_SEC=3, no press → buzzer falls after the 3rd en_1hz; alarm_hit after the 2nd tick → buzzer lasts 3 more ticks.
- alarm_hit and frame_done in the same cycle → mode_sel=2 and buzzer=1 next cycle; rst pulse mid-ALARM → buzzer=0 immediately, mode_sel=0.
